// File: rtl/decode_queue.sv
// decode_queue: buffered RV32I decode stage with FIFO, registered issue slot, flush and global stall
package decode_queue_pkg;
  typedef logic [5:0] openum_t;
  // Class bits sit above funct3 so most ops are a concatenation of fields
  localparam openum_t OPENUM_NOP = 6'd0, OPENUM_LUI = 6'd1, OPENUM_AUIPC = 6'd2, OPENUM_JAL = 6'd3,
    OPENUM_JALR = 6'd4, OPENUM_BEQ = 6'd8, OPENUM_BNE = 6'd9, OPENUM_BLT = 6'd12, OPENUM_BGE = 6'd13,
    OPENUM_BLTU = 6'd14, OPENUM_BGEU = 6'd15, OPENUM_LB = 6'd16, OPENUM_LH = 6'd17, OPENUM_LW = 6'd18,
    OPENUM_LBU = 6'd20, OPENUM_LHU = 6'd21, OPENUM_SB = 6'd24, OPENUM_SH = 6'd25, OPENUM_SW = 6'd26,
    OPENUM_ADDI = 6'd32, OPENUM_SLLI = 6'd33, OPENUM_SLTI = 6'd34, OPENUM_SLTIU = 6'd35,
    OPENUM_XORI = 6'd36, OPENUM_SRLI = 6'd37, OPENUM_ORI = 6'd38, OPENUM_ANDI = 6'd39,
    OPENUM_SRAI = 6'd45, OPENUM_ADD = 6'd48, OPENUM_SLL = 6'd49, OPENUM_SLT = 6'd50,
    OPENUM_SLTU = 6'd51, OPENUM_XOR = 6'd52, OPENUM_SRL = 6'd53, OPENUM_OR = 6'd54,
    OPENUM_AND = 6'd55, OPENUM_SUB = 6'd56, OPENUM_SRA = 6'd61;
  typedef struct packed {
    openum_t op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [31:0] imm;
    logic jump;
    logic store;
    logic load;
    logic branch;
    logic illegal;
  } dec_t;
  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic bad;
    f3 = i[14:12];
    f7 = i[31:25];
    bad = 1'b0;
    d = '0;
    d.rd = i[11:7];
    d.rs1 = i[19:15];
    d.rs2 = i[24:20];
    case (i[6:0])
      7'h37: begin d.op = OPENUM_LUI; d.imm = {i[31:12], 12'b0}; end
      7'h17: begin d.op = OPENUM_AUIPC; d.imm = {i[31:12], 12'b0}; end
      7'h6f: begin d.op = OPENUM_JAL; d.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; d.jump = 1'b1; end
      7'h67: begin d.op = OPENUM_JALR; d.imm = {{20{i[31]}}, i[31:20]}; d.jump = 1'b1; end
      7'h63: begin
        d.op = {3'b001, f3};
        d.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        d.rd = '0;
        d.jump = 1'b1;
        d.branch = 1'b1;
        bad = f3[2:1] == 2'b01;
      end
      7'h03: begin d.op = {3'b010, f3}; d.imm = {{20{i[31]}}, i[31:20]}; d.load = 1'b1; bad = f3 == 3'd3 || f3 > 3'd5; end
      7'h23: begin
        d.op = {3'b011, f3};
        d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        d.rd = '0;
        d.store = 1'b1;
        bad = f3 > 3'd2;
      end
      7'h13: begin
        d.op = {2'b10, f3 == 3'd5 && i[30], f3};
        d.imm = f3[1:0] == 2'b01 ? {27'b0, i[24:20]} : {{20{i[31]}}, i[31:20]};
        bad = f3 == 3'd1 ? f7 != 7'h00 : f3 == 3'd5 ? f7 != 7'h00 && f7 != 7'h20 : 1'b0;
      end
      7'h33: begin
        d.op = {2'b11, i[30], f3};
        bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      default: bad = 1'b1;
    endcase
    // Illegal words keep their register fields but drop every other decode result
    if (bad) begin
      d.op = OPENUM_NOP;
      d.imm = '0;
      d.rd = i[11:7];
      {d.jump, d.store, d.load, d.branch} = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction
endpackage

module decode_queue import decode_queue_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        in_pred_taken,
  output logic        out_valid,
  input  logic        out_ready,
  output openum_t     out_openum,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [31:0] out_imm,
  output logic [31:0] out_pc,
  output logic        out_pred_taken,
  output logic        out_is_jump,
  output logic        out_is_store,
  output logic        out_is_load,
  output logic        out_is_branch,
  output logic        out_is_illegal
);
  localparam int CW = PTR_W + 1;
  typedef struct packed {
    dec_t dec;
    logic [31:0] pc;
    logic pred;
  } slot_t;
  logic [64:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0] count;
  slot_t slot;
  logic push, load_slot, from_fifo, bypass, wr_fifo;
  logic [64:0] src;
  assign in_ready = !count[PTR_W];
  assign push = in_valid && in_ready;
  assign load_slot = !out_valid || out_ready;
  assign from_fifo = load_slot && count != '0;
  assign bypass = load_slot && count == '0 && push;
  assign wr_fifo = push && !bypass;
  assign src = from_fifo ? mem[rd_ptr] : {in_pred_taken, in_pc, in_inst};
  always_ff @(posedge clk_in)
    if (rst_in && rdy_in && !flush_in && wr_fifo) mem[wr_ptr] <= {in_pred_taken, in_pc, in_inst};
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      out_valid <= 1'b0;
      slot <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        out_valid <= 1'b0;
      end else begin
        if (wr_fifo) wr_ptr <= wr_ptr + PTR_W'(1);
        if (from_fifo) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CW'(wr_fifo) - CW'(from_fifo);
        if (load_slot) out_valid <= from_fifo || bypass;
        if (from_fifo || bypass) slot <= '{dec: decode(src[31:0]), pc: src[63:32], pred: src[64]};
      end
    end
  end
  assign out_openum = slot.dec.op;
  assign out_rd = slot.dec.rd;
  assign out_rs1 = slot.dec.rs1;
  assign out_rs2 = slot.dec.rs2;
  assign out_imm = slot.dec.imm;
  assign out_pc = slot.pc;
  assign out_pred_taken = slot.pred;
  assign out_is_jump = slot.dec.jump;
  assign out_is_store = slot.dec.store;
  assign out_is_load = slot.dec.load;
  assign out_is_branch = slot.dec.branch;
  assign out_is_illegal = slot.dec.illegal;
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Buffered, handshaked RV32I decode stage between instruction fetch and dispatch.
- Fetched instructions (with PC and branch-prediction bit) are pushed into a DEPTH-entry FIFO.
- The head entry is decoded combinationally and captured into a registered output slot, which issues to dispatch under a valid/ready handshake.
- Beyond the plain decoder, the block adds illegal-instruction detection, load/branch classification, flush on misprediction, and a global stall.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- PTR_W, 3, log2(DEPTH).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-low reset.
- rdy_in  input  1  global enable; when 0, all state holds.
- flush_in  input  1  misprediction flush; discards all buffered and output content.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  FIFO can accept; equals (count < DEPTH), registered-state based.
- in_inst  input  32  instruction word.
- in_pc  input  32  instruction PC.
- in_pred_taken  input  1  predictor decision for this instruction.
- out_valid  output  1  decoded entry held in the output slot.
- out_ready  input  1  dispatch accepts the entry.
- out_openum  output  OPENUM_TYPE  operation (OPENUM_* constants of the shared definitions header).
- out_rd, out_rs1, out_rs2  output  5 each  register indices.
- out_imm  output  32  immediate.
- out_pc  output  32  PC of the entry.
- out_pred_taken  output  1  passthrough of the prediction bit.
- out_is_jump, out_is_store, out_is_load, out_is_branch, out_is_illegal  output  1 each  classification flags.

Behaviour:
- Reset (rst_in=0 at a clock edge): count=0, pointers=0, out_valid=0, all out_* fields=0, out_openum=OPENUM_NOP, in_ready=1 on the next cycle. Reset dominates flush and rdy_in.
- Priority at each edge: reset > !rdy_in (hold everything) > flush > normal operation.
- Flush: count, read pointer and write pointer return to 0 and out_valid goes to 0. A same-cycle push is discarded, as is a same-cycle out handshake (dispatch must ignore it).
- Push occurs when in_valid && in_ready. Pop of the output slot occurs when out_valid && out_ready.
- The output slot loads when it is empty or being popped this cycle:
  - If FIFO count>0, it loads the decoded FIFO head and the read pointer advances.
  - Else, if a push occurs, it loads the decoded incoming instruction directly (bypass) and the FIFO is not written.
  - Else, out_valid=0.
- Latency: push at edge N into an empty block gives out_valid=1 after edge N. Total capacity is DEPTH+1.
- Simultaneous push and head-load with count>0: the FIFO writes and reads in the same cycle and count is unchanged. Pointers wrap modulo DEPTH.
- in_ready depends only on registered count, never on out_ready. At count=DEPTH a push is impossible and in_valid is ignored.
- Decode rules (combinational on the selected source):
  - rd, rs1 and rs2 come from fixed fields.
  - U-type: imm = {inst[31:12], 12'b0}.
  - JAL: J-imm, is_jump=1.
  - JALR: I-imm, is_jump=1.
  - Branch: B-imm, rd=0, is_jump=1, is_branch=1.
  - Store: S-imm, rd=0, is_store=1.
  - Load: I-imm, is_load=1.
  - OP-IMM: I-imm. For SLLI/SRLI/SRAI, imm = zero-extended inst[24:20].
  - OP: imm=0.
- Illegal: unknown opcode; an unused funct3 in load, store or branch; OP with funct7 other than 0000000, or 0100000 for ADD/SUB and SRL/SRA; shift-immediate with an illegal funct7. An illegal instruction gives openum=OPENUM_NOP, imm=0, is_illegal=1, all other flags 0, and rd, rs1 and rs2 still passed through.
- Output fields hold stable while out_valid && !out_ready.

Test Plan:
- Reset then single push: push inst 0x00500093 at PC 0x1000 → next cycle out_valid=1, openum=ADDI, rd=1, rs1=0, imm=5, out_pc=0x1000.
- Fill/backpressure: out_ready=0, push 10 instructions with DEPTH=8 → 9 accepted, in_ready=0 after count reaches 8. Release out_ready=1 → all 9 emerge in order with no bubbles.
- Simultaneous push/pop at count=4, held 20 cycles → count stays 4, pointers wrap, order preserved.
- Flush with count=5 and out_valid=1, plus a same-cycle push → next cycle out_valid=0, in_ready=1, pushed instruction never appears.
- Decode corner cases:
  - 0x40105013 (SRAI x0,x0,1) → SRAI, imm=1.
  - 0x02005013 (SRLI, funct7=0000001) → is_illegal=1, openum=NOP.
  - 0xFE000EE3 (BEQ x0,x0,-4) → imm=0xFFFFFFFC, rd=0, is_branch=1.
- rdy_in=0 for 3 cycles mid-stream with in_valid/out_ready toggling → no state change; the stream resumes intact.
